// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALU operation codes,
// opcode/funct values, mux select encodings and the sequencer state type.
package mips_ctrl_pkg;

   // ALU operation codes driven onto alu_op
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_NOP = 4'b1111;  // pass operand A through

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BRIMM = 2'b11;

   typedef enum logic [3:0] {
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_EXEC_I,
      S_WB_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_ERR
   } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct field to ALU operation decoder; flags unsupported funct codes.
module alu_op_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       legal
);

   // Unsupported funct codes yield NOP so an illegal EXEC_R cycle computes nothing
   always_comb begin
      alu_op = ALU_NOP;
      legal  = 1'b1;
      case (funct)
         FN_ADD, FN_ADDU: alu_op = ALU_ADD;
         FN_SUB, FN_SUBU: alu_op = ALU_SUB;
         FN_AND:          alu_op = ALU_AND;
         FN_OR:           alu_op = ALU_OR;
         FN_NOR:          alu_op = ALU_NOR;
         FN_SLT:          alu_op = ALU_SLT;
         default:         legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control sequencer: walks each instruction through
// fetch/decode/execute/memory/write-back, drives the datapath selects and ALU
// operation, and guards every memory request with a timeout into a sticky ERR.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       alu_positive,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ext_zero,
   output logic [3:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic       bus_err
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       r_alu_op;
   logic             r_legal;
   logic             wait_expired;

   alu_op_decode u_alu_op_decode (
      .funct  (funct),
      .alu_op (r_alu_op),
      .legal  (r_legal)
   );

   // A request times out when this is its last allowed cycle and memory is still not ready
   assign wait_expired = !mem_ready && (cnt_q == CNT_LIMIT);

   // Next-state and output decode; outputs follow the current state, with
   // mem_ready, opcode/funct and ALU flags qualifying the strobes that need them
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PCSRC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      ext_zero   = 1'b0;
      alu_op     = ALU_NOP;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      case (state_q)
         S_BOOT: state_d = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_ERR;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_BRIMM;
            alu_op    = ALU_ADD;
            case (opcode)
               OP_RTYPE:                                 state_d = S_EXEC_R;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
               OP_LW, OP_SW:                             state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BGTZ:                  state_d = S_BRANCH;
               OP_J:                                     state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = r_alu_op;
            if (r_legal) begin
               state_d = S_WB_R;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_SLTI: alu_op = ALU_SLT;
               OP_ANDI: begin
                  alu_op   = ALU_AND;
                  ext_zero = 1'b1;
               end
               OP_ORI: begin
                  alu_op   = ALU_OR;
                  ext_zero = 1'b1;
               end
               default: alu_op = ALU_ADD;
            endcase
            state_d = S_WB_I;
         end
         S_WB_I: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready)         state_d = S_MEM_WB;
            else if (wait_expired) state_d = S_ERR;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready)         state_d = S_FETCH;
            else if (wait_expired) state_d = S_ERR;
         end
         S_BRANCH: begin
            pc_src    = PCSRC_ALUOUT;
            alu_src_a = 1'b1;
            case (opcode)
               OP_BEQ: begin
                  alu_op = ALU_SUB;
                  pc_en  = alu_zero;
               end
               OP_BNE: begin
                  alu_op = ALU_SUB;
                  pc_en  = !alu_zero;
               end
               OP_BGTZ: pc_en = alu_positive;
               default: ;
            endcase
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = PCSRC_JUMP;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_ERR: bus_err = 1'b1;
         default: state_d = S_BOOT;
      endcase
   end

   // Wait counter restarts on every state change and counts unanswered request cycles
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)       cnt_d = '0;
      else if (mem_req && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
   end

   // State and wait-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-cycle expected output vectors are queued as
// stimulus is applied and compared against the DUT on the falling edge.
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       alu_zero, alu_positive, mem_ready;
   logic       mem_req, mem_we, iord, ir_write, pc_en;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_zero;
   logic [3:0] alu_op;
   logic       reg_write, reg_dst, mem_to_reg, illegal, bus_err;

   logic [19:0] outv;
   logic [19:0] exp_q[$];
   string       tag_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mips_mc_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .alu_positive(alu_positive), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .ext_zero(ext_zero), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err)
   );

   assign outv = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                  ext_zero, alu_op, reg_write, reg_dst, mem_to_reg, illegal, bus_err};

   // Field order: req we iord irw pc_en pc_src src_a src_b ext alu_op rw rdst m2r ill berr
   function automatic logic [19:0] mk(input logic rq, we, io, irw, pce, input logic [1:0] ps,
                                      input logic sa, input logic [1:0] sb, input logic ez,
                                      input logic [3:0] op, input logic rw, rd, m2r, ill, be);
      return {rq, we, io, irw, pce, ps, sa, sb, ez, op, rw, rd, m2r, ill, be};
   endfunction

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", tag, obs, expv);
      end
   endtask

   // Called just after a rising edge: apply inputs, queue expectation, compare at falling edge
   task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic p, input logic r, input logic [19:0] e);
      opcode = op; funct = fn; alu_zero = z; alu_positive = p; mem_ready = r;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      chk(tag_q.pop_front(), outv, exp_q.pop_front());
      @(posedge clk); #1;
   endtask

   logic [19:0] V_DEF, V_FW, V_FR, V_DEC, V_DEC_ILL, V_WBR, V_WBI, V_MADDR, V_ERR;

   initial begin
      V_DEF     = mk(0,0,0,0,0,2'b00,0,2'b00,0,4'b1111,0,0,0,0,0);
      V_FW      = mk(1,0,0,0,0,2'b00,0,2'b01,0,4'b0010,0,0,0,0,0);
      V_FR      = mk(1,0,0,1,1,2'b00,0,2'b01,0,4'b0010,0,0,0,0,0);
      V_DEC     = mk(0,0,0,0,0,2'b00,0,2'b11,0,4'b0010,0,0,0,0,0);
      V_DEC_ILL = mk(0,0,0,0,0,2'b00,0,2'b11,0,4'b0010,0,0,0,1,0);
      V_WBR     = mk(0,0,0,0,0,2'b00,0,2'b00,0,4'b1111,1,1,0,0,0);
      V_WBI     = mk(0,0,0,0,0,2'b00,0,2'b00,0,4'b1111,1,0,0,0,0);
      V_MADDR   = mk(0,0,0,0,0,2'b00,1,2'b10,0,4'b0010,0,0,0,0,0);
      V_ERR     = mk(0,0,0,0,0,2'b00,0,2'b00,0,4'b1111,0,0,0,0,1);

      rst_n = 1'b0;
      opcode = '0; funct = '0; alu_zero = 0; alu_positive = 0; mem_ready = 0;
      @(posedge clk); #1;
      step("reset_hold", 6'h00, 6'h00, 0, 0, 1, V_DEF);
      rst_n = 1'b1;
      step("boot", 6'h00, 6'h00, 0, 0, 0, V_DEF);
      step("fetch_wait0", 6'h00, 6'h00, 0, 0, 0, V_FW);
      step("fetch_wait1", 6'h00, 6'h00, 0, 0, 0, V_FW);
      // Asynchronous reset in the middle of a fetch request
      rst_n = 1'b0; #1;
      chk("reset_async_drop", outv, V_DEF);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("boot2", 6'h00, 6'h00, 0, 0, 0, V_DEF);

      // R-type add, zero wait
      step("add_fetch", 6'h00, 6'h20, 0, 0, 1, V_FR);
      step("add_decode", 6'h00, 6'h20, 0, 0, 0, V_DEC);
      step("add_exec", 6'h00, 6'h20, 0, 0, 0, mk(0,0,0,0,0,2'b00,1,2'b00,0,4'b0010,0,0,0,0,0));
      step("add_wb", 6'h00, 6'h20, 0, 0, 0, V_WBR);

      // R-type sub and nor
      step("sub_fetch", 6'h00, 6'h22, 0, 0, 1, V_FR);
      step("sub_decode", 6'h00, 6'h22, 0, 0, 0, V_DEC);
      step("sub_exec", 6'h00, 6'h22, 0, 0, 0, mk(0,0,0,0,0,2'b00,1,2'b00,0,4'b0110,0,0,0,0,0));
      step("sub_wb", 6'h00, 6'h22, 0, 0, 0, V_WBR);
      step("nor_fetch", 6'h00, 6'h27, 0, 0, 1, V_FR);
      step("nor_decode", 6'h00, 6'h27, 0, 0, 0, V_DEC);
      step("nor_exec", 6'h00, 6'h27, 0, 0, 0, mk(0,0,0,0,0,2'b00,1,2'b00,0,4'b1100,0,0,0,0,0));
      step("nor_wb", 6'h00, 6'h27, 0, 0, 0, V_WBR);

      // lw with three wait cycles in MEM_RD (ready arrives in the limit cycle)
      step("lw_fetch", 6'h23, 6'h00, 0, 0, 1, V_FR);
      step("lw_decode", 6'h23, 6'h00, 0, 0, 0, V_DEC);
      step("lw_addr", 6'h23, 6'h00, 0, 0, 0, V_MADDR);
      for (int i = 0; i < 3; i++)
         step("lw_rd_wait", 6'h23, 6'h00, 0, 0, 0, mk(1,0,1,0,0,2'b00,0,2'b00,0,4'b1111,0,0,0,0,0));
      step("lw_rd_ready", 6'h23, 6'h00, 0, 0, 1, mk(1,0,1,0,0,2'b00,0,2'b00,0,4'b1111,0,0,0,0,0));
      step("lw_wb", 6'h23, 6'h00, 0, 0, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,4'b1111,1,0,1,0,0));

      // sw, zero wait
      step("sw_fetch", 6'h2B, 6'h00, 0, 0, 1, V_FR);
      step("sw_decode", 6'h2B, 6'h00, 0, 0, 0, V_DEC);
      step("sw_addr", 6'h2B, 6'h00, 0, 0, 0, V_MADDR);
      step("sw_wr", 6'h2B, 6'h00, 0, 0, 1, mk(1,1,1,0,0,2'b00,0,2'b00,0,4'b1111,0,0,0,0,0));

      // Branches
      step("beq_t_fetch", 6'h04, 6'h00, 1, 0, 1, V_FR);
      step("beq_t_decode", 6'h04, 6'h00, 1, 0, 0, V_DEC);
      step("beq_taken", 6'h04, 6'h00, 1, 0, 0, mk(0,0,0,0,1,2'b01,1,2'b00,0,4'b0110,0,0,0,0,0));
      step("beq_n_fetch", 6'h04, 6'h00, 0, 0, 1, V_FR);
      step("beq_n_decode", 6'h04, 6'h00, 0, 0, 0, V_DEC);
      step("beq_not_taken", 6'h04, 6'h00, 0, 0, 0, mk(0,0,0,0,0,2'b01,1,2'b00,0,4'b0110,0,0,0,0,0));
      step("bne_fetch", 6'h05, 6'h00, 0, 0, 1, V_FR);
      step("bne_decode", 6'h05, 6'h00, 0, 0, 0, V_DEC);
      step("bne_taken", 6'h05, 6'h00, 0, 0, 0, mk(0,0,0,0,1,2'b01,1,2'b00,0,4'b0110,0,0,0,0,0));
      step("bgtz_fetch", 6'h07, 6'h00, 0, 1, 1, V_FR);
      step("bgtz_decode", 6'h07, 6'h00, 0, 1, 0, V_DEC);
      step("bgtz_taken", 6'h07, 6'h00, 0, 1, 0, mk(0,0,0,0,1,2'b01,1,2'b00,0,4'b1111,0,0,0,0,0));

      // Jump
      step("j_fetch", 6'h02, 6'h00, 0, 0, 1, V_FR);
      step("j_decode", 6'h02, 6'h00, 0, 0, 0, V_DEC);
      step("j_exec", 6'h02, 6'h00, 0, 0, 0, mk(0,0,0,0,1,2'b10,0,2'b00,0,4'b1111,0,0,0,0,0));

      // I-type andi and addi
      step("andi_fetch", 6'h0C, 6'h00, 0, 0, 1, V_FR);
      step("andi_decode", 6'h0C, 6'h00, 0, 0, 0, V_DEC);
      step("andi_exec", 6'h0C, 6'h00, 0, 0, 0, mk(0,0,0,0,0,2'b00,1,2'b10,1,4'b0000,0,0,0,0,0));
      step("andi_wb", 6'h0C, 6'h00, 0, 0, 0, V_WBI);
      step("addi_fetch", 6'h08, 6'h00, 0, 0, 1, V_FR);
      step("addi_decode", 6'h08, 6'h00, 0, 0, 0, V_DEC);
      step("addi_exec", 6'h08, 6'h00, 0, 0, 0, mk(0,0,0,0,0,2'b00,1,2'b10,0,4'b0010,0,0,0,0,0));
      step("addi_wb", 6'h08, 6'h00, 0, 0, 0, V_WBI);

      // Illegal opcode, then illegal funct; each returns straight to FETCH
      step("ill_op_fetch", 6'h3F, 6'h00, 0, 0, 1, V_FR);
      step("ill_op_decode", 6'h3F, 6'h00, 0, 0, 0, V_DEC_ILL);
      step("ill_fn_fetch", 6'h00, 6'h3F, 0, 0, 1, V_FR);
      step("ill_fn_decode", 6'h00, 6'h3F, 0, 0, 0, V_DEC);
      step("ill_fn_exec", 6'h00, 6'h3F, 0, 0, 0, mk(0,0,0,0,0,2'b00,1,2'b00,0,4'b1111,0,0,0,1,0));

      // Fetch with ready in the 4th (limit) cycle completes normally
      for (int i = 0; i < 3; i++)
         step("lim_fetch_wait", 6'h02, 6'h00, 0, 0, 0, V_FW);
      step("lim_fetch_ready", 6'h02, 6'h00, 0, 0, 1, V_FR);
      step("lim_decode", 6'h02, 6'h00, 0, 0, 0, V_DEC);
      step("lim_jump", 6'h02, 6'h00, 0, 0, 0, mk(0,0,0,0,1,2'b10,0,2'b00,0,4'b1111,0,0,0,0,0));

      // Fetch never answered: ERR after 4 cycles, sticky even when ready appears
      for (int i = 0; i < 4; i++)
         step("to_fetch_wait", 6'h00, 6'h00, 0, 0, 0, V_FW);
      step("to_err0", 6'h00, 6'h00, 0, 0, 1, V_ERR);
      step("to_err1", 6'h00, 6'h00, 0, 0, 1, V_ERR);
      step("to_err2", 6'h00, 6'h00, 0, 0, 0, V_ERR);

      // Reset clears the error
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("rec_boot", 6'h00, 6'h00, 0, 0, 0, V_DEF);
      step("rec_fetch", 6'h00, 6'h00, 0, 0, 0, V_FW);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
